irq_seq: RTL
============

IRQ_SEQ -- requirements
Module: irq_seq

Interface
REQ-001 Parameter IRQ_VECTOR, default 8'h01: program address loaded into PC on interrupt entry.
REQ-002 Parameter IE_BIT, default 4: index of the interrupt-enable bit in the 6-bit flags word.
REQ-003 Parameter IF_BIT, default 5: index of the interrupt-active bit in the 6-bit flags word.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 irq  in  1  external interrupt request, level-sensitive, synchronous to clk.
REQ-007 instr_boundary  in  1  pulse: current instruction has completed and the next fetch has not started.
REQ-008 rti_req  in  1  pulse: decoded RTI instruction that requests a return.
REQ-009 pc_in  in  8  PC of the next instruction to execute.
REQ-010 flags_in  in  6  current CPU flags.
REQ-011 stack_op_end  in  1  one-cycle pulse from the stack unit: the requested push or pop has finished.
REQ-012 stack_pc  in  8  PC value popped by the stack unit.
REQ-013 stack_flags  in  6  flags value popped by the stack unit.
REQ-014 stack_op_ongoing  out  1  request to the stack unit; held high until stack_op_end.
REQ-015 push_or_pop  out  1  1 = push, 0 = pop; valid whenever stack_op_ongoing is high.
REQ-016 stack_pc_out  out  8  PC value to push.
REQ-017 stack_flags_out  out  6  flags value to push.
REQ-018 cpu_stall  out  1  freezes instruction fetch and execute.
REQ-019 pc_load  out  1  one-cycle strobe: the CPU loads pc_val into PC.
REQ-020 pc_val  out  8  PC value to load.
REQ-021 flags_load  out  1  one-cycle strobe: the CPU loads flags_val into its flags.
REQ-022 flags_val  out  6  flags value to load.
REQ-023 irq_ack  out  1  one-cycle pulse on interrupt entry.

Function
REQ-024 The FSM SHALL have the states IDLE, PUSH, VECTOR, POP and RESTORE, encoded in 3 bits; any unused encoding SHALL return to IDLE on the next clock.
REQ-025 In IDLE, when instr_boundary=1, irq=1, flags_in[IE_BIT]=1 and flags_in[IF_BIT]=0, the block SHALL capture pc_in and flags_in into internal registers and go to PUSH.
REQ-026 In IDLE, rti_req=1 SHALL take the block to POP, whatever the state of irq.
REQ-027 If rti_req and an interrupt-entry condition occur in the same cycle, rti_req SHALL win; the interrupt is taken at a later boundary.
REQ-028 In PUSH and POP, stack_op_ongoing SHALL be 1, push_or_pop SHALL be 1 in PUSH and 0 in POP, and the captured values SHALL drive stack_pc_out and stack_flags_out.
REQ-029 In PUSH, stack_op_end=1 SHALL take the block to VECTOR; stack_op_ongoing SHALL drop in the cycle after that edge.
REQ-030 VECTOR SHALL last exactly one cycle, with the following outputs, then return to IDLE:
- pc_load=1 and pc_val=IRQ_VECTOR;
- flags_load=1 and flags_val = captured flags with IE_BIT cleared and IF_BIT set;
- irq_ack=1.
REQ-031 In POP, stack_op_end=1 SHALL register stack_pc and stack_flags and take the block to RESTORE.
REQ-032 RESTORE SHALL last exactly one cycle with pc_load=1, pc_val=registered stack_pc, flags_load=1 and flags_val=registered stack_flags, then return to IDLE.
REQ-033 cpu_stall SHALL be 1 in every state other than IDLE, and also in the IDLE cycle that accepts an entry or an RTI.
REQ-034 A stack_op_end received while in IDLE, VECTOR or RESTORE SHALL be ignored.
REQ-035 irq and rti_req SHALL be ignored outside IDLE; nested entry is blocked by the IF_BIT check until RTI restores the flags.
REQ-036 A stack operation SHALL have no timeout; PUSH and POP SHALL hold until stack_op_end arrives.

Reset
REQ-037 Asserting rst low SHALL asynchronously force the state to IDLE and drive these outputs low: stack_op_ongoing, push_or_pop, pc_load, flags_load, irq_ack, cpu_stall.
REQ-038 Asserting rst low SHALL also clear to 0 all data outputs and all captured registers.
REQ-039 Reset asserted during PUSH or POP SHALL abandon the stack operation with no load strobe; after release the block starts in IDLE.

Verification
REQ-040 Interrupt entry: flags_in=6'b010000, pc_in=8'h37, irq=1 and an instr_boundary pulse; stack_op_end after 3 cycles -> push_or_pop=1 with stack_pc_out=8'h37 and stack_flags_out=6'b010000 during PUSH, then one cycle of pc_load with pc_val=8'h01, flags_val=6'b100000 and irq_ack=1.
REQ-041 Return: rti_req pulse, then stack_op_end with stack_pc=8'h37 and stack_flags=6'b010000 -> push_or_pop=0 during POP, then one RESTORE cycle with pc_val=8'h37 and flags_val=6'b010000.
REQ-042 Masking: irq=1 with IE=0, or with IF=1, across 10 instruction boundaries -> stack_op_ongoing stays 0 and no irq_ack.
REQ-043 Simultaneous events: rti_req and an entry condition in the same cycle -> the POP sequence runs first; the PUSH sequence starts only at the next qualifying boundary.
REQ-044 Reset mid-PUSH: assert rst low while stack_op_ongoing=1 -> all outputs go low immediately, no pc_load follows, and a fresh entry succeeds after release.
REQ-045 Spurious end: a stack_op_end pulse in IDLE -> no state change and no strobes.

Source files
------------

// File: rtl/irq_seq.sv
// -----------------------------------------------------------------------------
// irq_seq -- interrupt entry / return sequencer for a small 8-bit CPU.
//
// On an accepted interrupt at an instruction boundary, the current PC and flags
// are captured and pushed through the stack unit. The PC is then vectored to
// IRQ_VECTOR, and the flags are reloaded with interrupts masked and the
// interrupt-active bit set. On RTI, PC and flags are popped and restored.
//
// Ports
//   clk, rst          : clock; asynchronous active-low reset
//   irq               : level interrupt request
//   instr_boundary    : instruction completed, next fetch not yet started
//   rti_req           : decoded RTI
//   pc_in, flags_in   : live CPU PC / flags
//   stack_op_end      : stack unit finished the current push/pop
//   stack_pc/_flags   : values returned by a pop
//   stack_op_ongoing  : stack request, held until stack_op_end
//   push_or_pop       : 1 = push, 0 = pop
//   stack_pc_out/_flags_out : values to push
//   cpu_stall         : freezes fetch/execute
//   pc_load/pc_val, flags_load/flags_val : one-cycle CPU register loads
//   irq_ack           : one-cycle pulse on interrupt entry
// -----------------------------------------------------------------------------
module irq_seq #(
    parameter logic [7:0] IRQ_VECTOR = 8'h01,
    parameter int         IE_BIT     = 4,
    parameter int         IF_BIT     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq,
    input  logic       instr_boundary,
    input  logic       rti_req,
    input  logic [7:0] pc_in,
    input  logic [5:0] flags_in,
    input  logic       stack_op_end,
    input  logic [7:0] stack_pc,
    input  logic [5:0] stack_flags,
    output logic       stack_op_ongoing,
    output logic       push_or_pop,
    output logic [7:0] stack_pc_out,
    output logic [5:0] stack_flags_out,
    output logic       cpu_stall,
    output logic       pc_load,
    output logic [7:0] pc_val,
    output logic       flags_load,
    output logic [5:0] flags_val,
    output logic       irq_ack
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_POP     = 3'd3,
        ST_RESTORE = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] cap_pc_reg;
    logic [5:0] cap_flags_reg;
    logic [7:0] pop_pc_reg;
    logic [5:0] pop_flags_reg;
    logic       capture_en;
    logic       pop_latch_en;
    logic       entry_ok;
    logic [5:0] vector_flags;

    // An interrupt is only taken while enabled and not already in a handler;
    // the IF check is what blocks nesting until RTI restores the old flags.
    assign entry_ok = instr_boundary & irq & flags_in[IE_BIT] & ~flags_in[IF_BIT];

    // Handler-entry flags: captured flags with IE cleared and IF set.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_vec_flags
            if (gi == IE_BIT) begin : g_ie
                assign vector_flags[gi] = 1'b0;
            end else if (gi == IF_BIT) begin : g_if
                assign vector_flags[gi] = 1'b1;
            end else begin : g_keep
                assign vector_flags[gi] = cap_flags_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cap_pc_reg    <= 8'h00;
            cap_flags_reg <= 6'h00;
            pop_pc_reg    <= 8'h00;
            pop_flags_reg <= 6'h00;
        end else begin
            state_reg <= state_next;
            if (capture_en) begin
                cap_pc_reg    <= pc_in;
                cap_flags_reg <= flags_in;
            end
            if (pop_latch_en) begin
                pop_pc_reg    <= stack_pc;
                pop_flags_reg <= stack_flags;
            end
        end
    end

    // Pushed values come straight from the capture registers, which are
    // cleared by reset, so these outputs are zero while reset is asserted.
    assign stack_pc_out    = cap_pc_reg;
    assign stack_flags_out = cap_flags_reg;

    always_comb begin
        state_next       = state_reg;
        capture_en       = 1'b0;
        pop_latch_en     = 1'b0;
        stack_op_ongoing = 1'b0;
        push_or_pop      = 1'b0;
        cpu_stall        = 1'b0;
        pc_load          = 1'b0;
        pc_val           = 8'h00;
        flags_load       = 1'b0;
        flags_val        = 6'h00;
        irq_ack          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // RTI takes priority; a pending interrupt retries at a later boundary.
                if (rti_req) begin
                    state_next = ST_POP;
                    cpu_stall  = 1'b1;
                end else if (entry_ok) begin
                    state_next = ST_PUSH;
                    capture_en = 1'b1;
                    cpu_stall  = 1'b1;
                end
            end
            ST_PUSH: begin
                stack_op_ongoing = 1'b1;
                push_or_pop      = 1'b1;
                cpu_stall        = 1'b1;
                if (stack_op_end) begin
                    state_next = ST_VECTOR;
                end
            end
            ST_VECTOR: begin
                cpu_stall  = 1'b1;
                pc_load    = 1'b1;
                pc_val     = IRQ_VECTOR;
                flags_load = 1'b1;
                flags_val  = vector_flags;
                irq_ack    = 1'b1;
                state_next = ST_IDLE;
            end
            ST_POP: begin
                stack_op_ongoing = 1'b1;
                cpu_stall        = 1'b1;
                if (stack_op_end) begin
                    pop_latch_en = 1'b1;
                    state_next   = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                cpu_stall  = 1'b1;
                pc_load    = 1'b1;
                pc_val     = pop_pc_reg;
                flags_load = 1'b1;
                flags_val  = pop_flags_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
